// File: rtl/pc_predict_if.sv
// pc_predict_if: fetch-side bundle between the PC/BTB unit and its neighbours.
//   Control in : en, stall, bp_clear
//   Fetch out  : pc, pc_4, pred_hit, pred_taken, pred_target
//   Resolve in : res_valid, res_pc, res_taken, res_target, res_mispredict, res_redirect
// Modports: master = surrounding pipeline (drives control/resolve), slave = pc_predict_unit.
interface pc_predict_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              en;
    logic              stall;
    logic              bp_clear;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_4;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              res_valid;
    logic [ADDR_W-1:0] res_pc;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target;
    logic              res_mispredict;
    logic [ADDR_W-1:0] res_redirect;

    modport master (
        output en, stall, bp_clear,
        output res_valid, res_pc, res_taken, res_target, res_mispredict, res_redirect,
        input  pc, pc_4, pred_hit, pred_taken, pred_target
    );

    modport slave (
        input  en, stall, bp_clear,
        input  res_valid, res_pc, res_taken, res_target, res_mispredict, res_redirect,
        output pc, pc_4, pred_hit, pred_taken, pred_target
    );
endinterface

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: fetch program counter with a direct-mapped BTB and per-entry
// saturating direction counters.
//   clk, rst : clock and synchronous active-high reset
//   bus      : pc_predict_if.slave (control, fetch prediction outputs, resolve/train inputs)
// Lookup is combinational on the registered pc; training and redirects take effect on the
// following rising edge.
module pc_predict_unit #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2
) (
    input logic         clk,
    input logic         rst,
    pc_predict_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CNT_W-1:0]  ctr_q    [ENTRIES];

    // Lookup
    logic [IDX_W-1:0] idx;
    logic             hit;
    assign idx = pc_q[IDX_W-1:0];
    assign hit = valid_q[idx] && (tag_q[idx] == pc_q[ADDR_W-1:IDX_W]);

    assign bus.pc          = pc_q;
    assign bus.pc_4        = pc_q + ADDR_W'(1);
    assign bus.pred_hit    = hit;
    assign bus.pred_taken  = hit && ctr_q[idx][CNT_W-1];
    assign bus.pred_target = hit ? target_q[idx] : '0;

    // Next PC: a mispredict redirect overrides stall
    always_comb begin
        pc_d = bus.pc_4;
        if (bus.res_valid && bus.res_mispredict) begin
            pc_d = bus.res_redirect;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.pred_taken) begin
            pc_d = bus.pred_target;
        end
    end

    // Training decode
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_hit;
    logic             ent_we;  // valid/tag/target write (taken: allocate or refresh)
    logic             ctr_we;
    logic [CNT_W-1:0] ctr_new;

    assign r_idx = bus.res_pc[IDX_W-1:0];
    assign r_tag = bus.res_pc[ADDR_W-1:IDX_W];
    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    always_comb begin
        ent_we  = 1'b0;
        ctr_we  = 1'b0;
        ctr_new = ctr_q[r_idx];
        if (bus.en && bus.res_valid && !bus.bp_clear) begin
            if (r_hit) begin
                ctr_we = 1'b1;
                if (bus.res_taken) begin
                    ent_we  = 1'b1;
                    ctr_new = (ctr_q[r_idx] == '1) ? ctr_q[r_idx] : ctr_q[r_idx] + CNT_W'(1);
                end else begin
                    ctr_new = (ctr_q[r_idx] == '0) ? ctr_q[r_idx] : ctr_q[r_idx] - CNT_W'(1);
                end
            end else if (bus.res_taken) begin
                ent_we  = 1'b1;
                ctr_we  = 1'b1;
                ctr_new = CNT_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= CNT_WNT;
            end
        end else if (bus.en) begin
            pc_q <= pc_d;
            if (bus.bp_clear) begin
                valid_q <= '0;
            end else if (ent_we) begin
                valid_q[r_idx] <= 1'b1;
            end
            if (ctr_we) begin
                ctr_q[r_idx] <= ctr_new;
            end
        end
    end

    // Tag/target need no reset: they are qualified by valid_q
    always_ff @(posedge clk) begin
        if (!rst && ent_we) begin
            tag_q[r_idx]    <= r_tag;
            target_q[r_idx] <= bus.res_target;
        end
    end
endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed testbench for pc_predict_unit. The driver applies one cycle of stimulus per
// step and queues the outputs expected after that clock edge; a monitor on the falling
// edge pops and compares them.
module tb_pc_predict_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_predict_if #(.ADDR_W(10)) bus ();

    pc_predict_unit #(
        .ADDR_W (10),
        .ENTRIES(16),
        .CNT_W  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string      name;
        logic [9:0] pc;
        logic       hit;
        logic       taken;
        logic [9:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       x;
            logic [9:0] x_pc4;
            x     = exp_q.pop_front();
            x_pc4 = x.pc + 10'd1;
            n_checks++;
            if ({bus.pc, bus.pc_4, bus.pred_hit, bus.pred_taken, bus.pred_target} !==
                {x.pc, x_pc4, x.hit, x.taken, x.tgt}) begin
                n_fail++;
                $display("FAIL %s: got pc=%h pc_4=%h hit=%b taken=%b tgt=%h, want pc=%h pc_4=%h hit=%b taken=%b tgt=%h",
                         x.name, bus.pc, bus.pc_4, bus.pred_hit, bus.pred_taken,
                         bus.pred_target, x.pc, x_pc4, x.hit, x.taken, x.tgt);
            end
        end
    end

    task automatic step(input string name, input logic r, input logic e, input logic st,
                        input logic clr, input logic rv, input logic [9:0] rpc,
                        input logic rtk, input logic [9:0] rtgt, input logic rmis,
                        input logic [9:0] rred, input logic [9:0] xpc, input logic xhit,
                        input logic xtk, input logic [9:0] xtgt);
        exp_t x;
        @(negedge clk);
        #1;
        rst                = r;
        bus.en             = e;
        bus.stall          = st;
        bus.bp_clear       = clr;
        bus.res_valid      = rv;
        bus.res_pc         = rpc;
        bus.res_taken      = rtk;
        bus.res_target     = rtgt;
        bus.res_mispredict = rmis;
        bus.res_redirect   = rred;
        x.name  = name;
        x.pc    = xpc;
        x.hit   = xhit;
        x.taken = xtk;
        x.tgt   = xtgt;
        exp_q.push_back(x);
    endtask

    // Plain advance with en=1, no resolve
    task automatic adv(input string name, input logic [9:0] xpc, input logic xhit,
                       input logic xtk, input logic [9:0] xtgt);
        step(name, 0, 1, 0, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0, xpc, xhit, xtk, xtgt);
    endtask

    // Resolve with mispredict redirect, so training and pc move together
    task automatic rsv(input string name, input logic [9:0] rpc, input logic rtk,
                       input logic [9:0] rtgt, input logic [9:0] rred, input logic [9:0] xpc,
                       input logic xhit, input logic xtk, input logic [9:0] xtgt);
        step(name, 0, 1, 0, 0, 1, rpc, rtk, rtgt, 1, rred, xpc, xhit, xtk, xtgt);
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.stall = 1'b0; bus.bp_clear = 1'b0;
        bus.res_valid = 1'b0; bus.res_pc = '0; bus.res_taken = 1'b0;
        bus.res_target = '0; bus.res_mispredict = 1'b0; bus.res_redirect = '0;

        step("reset", 1, 0, 0, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0, 10'h000, 0, 0, 10'h000);
        adv("seq1", 10'h001, 0, 0, 10'h000);
        adv("seq2", 10'h002, 0, 0, 10'h000);
        adv("seq3", 10'h003, 0, 0, 10'h000);
        step("en_low_hold", 0, 0, 0, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0, 10'h003, 0, 0, 10'h000);
        // Allocate pc 5 -> 0x20 without redirect
        step("alloc5", 0, 1, 0, 0, 1, 10'h005, 1, 10'h020, 0, 10'h0, 10'h004, 0, 0, 10'h000);
        adv("hit5", 10'h005, 1, 1, 10'h020);
        adv("follow_pred", 10'h020, 0, 0, 10'h000);
        // Counter down 2->1->0->0, then up 0->1->2->3->3
        rsv("ctr_dn1", 10'h005, 0, 10'h000, 10'h005, 10'h005, 1, 0, 10'h020);
        rsv("ctr_dn0", 10'h005, 0, 10'h000, 10'h005, 10'h005, 1, 0, 10'h020);
        rsv("ctr_sat0", 10'h005, 0, 10'h000, 10'h005, 10'h005, 1, 0, 10'h020);
        rsv("ctr_up1", 10'h005, 1, 10'h020, 10'h005, 10'h005, 1, 0, 10'h020);
        rsv("ctr_up2", 10'h005, 1, 10'h020, 10'h005, 10'h005, 1, 1, 10'h020);
        rsv("ctr_up3", 10'h005, 1, 10'h020, 10'h005, 10'h005, 1, 1, 10'h020);
        rsv("ctr_sat3_tgt", 10'h005, 1, 10'h024, 10'h005, 10'h005, 1, 1, 10'h024);
        // Alias on index 5 with tag 1
        rsv("alias_miss", 10'h015, 0, 10'h000, 10'h015, 10'h015, 0, 0, 10'h000);
        adv("alias_next", 10'h016, 0, 0, 10'h000);
        rsv("alias_alloc", 10'h015, 1, 10'h030, 10'h015, 10'h015, 1, 1, 10'h030);
        adv("alias_follow", 10'h030, 0, 0, 10'h000);
        rsv("old_tag_miss", 10'h005, 0, 10'h000, 10'h005, 10'h005, 0, 0, 10'h000);
        adv("old_tag_next", 10'h006, 0, 0, 10'h000);
        // Redirect beats stall; stall alone holds; en=0 blocks redirect
        step("stall_redir", 0, 1, 1, 0, 1, 10'h03F, 0, 10'h0, 1, 10'h040, 10'h040, 0, 0, 10'h000);
        step("stall_hold", 0, 1, 1, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0, 10'h040, 0, 0, 10'h000);
        step("en0_redir", 0, 0, 0, 0, 1, 10'h03F, 0, 10'h0, 1, 10'h100, 10'h040, 0, 0, 10'h000);
        // Wrap
        rsv("to_top", 10'h3FF, 0, 10'h000, 10'h3FF, 10'h3FF, 0, 0, 10'h000);
        adv("wrap", 10'h000, 0, 0, 10'h000);
        // bp_clear beats same-cycle allocation of pc 7 and wipes entry 5
        step("clr_alloc", 0, 1, 0, 1, 1, 10'h007, 1, 10'h055, 1, 10'h007, 10'h007, 0, 0, 10'h000);
        rsv("clr_wiped", 10'h015, 0, 10'h000, 10'h015, 10'h015, 0, 0, 10'h000);
        rsv("realloc7", 10'h007, 1, 10'h011, 10'h007, 10'h007, 1, 1, 10'h011);
        // Reset beats redirect and clears BTB
        step("rst_wins", 1, 1, 0, 0, 1, 10'h007, 1, 10'h022, 1, 10'h080, 10'h000, 0, 0, 10'h000);
        rsv("rst_cleared", 10'h03F, 0, 10'h000, 10'h007, 10'h007, 0, 0, 10'h000);

        // Drain the scoreboard with a bound
        begin
            int guard = 0;
            while (exp_q.size() > 0 && guard < 10) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Parametrised fetch-stage program counter with an integrated direct-mapped branch target buffer (BTB) and per-entry saturating direction counters. It holds the instruction-memory word address and predicts the next fetch address from the BTB. It applies redirects from the execute-stage branch resolver and trains the BTB from resolved branches and jumps. It sits between the hazard unit (stall) and instruction memory, replacing the fixed-size PC/BHT pair.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- ENTRIES, 16, BTB entries; power of two, 2..ADDR_W-indexable; IDX_W = log2(ENTRIES)
- CNT_W, 2, direction counter width, 1..4
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; when low, PC and BTB hold
- stall  in  1  hazard stall; PC holds unless a redirect is present
- bp_clear  in  1  invalidate all BTB entries
- pc  out  ADDR_W  current fetch address (registered)
- pc_4  out  ADDR_W  pc + 1, modulo 2^ADDR_W
- pred_hit  out  1  BTB entry valid and tag-matched for pc
- pred_taken  out  1  pred_hit and counter MSB set
- pred_target  out  ADDR_W  stored target of matched entry (0 when !pred_hit)
- res_valid  in  1  a branch/jump resolved this cycle
- res_pc  in  ADDR_W  address of resolved instruction
- res_taken  in  1  actual direction
- res_target  in  ADDR_W  actual taken target
- res_mispredict  in  1  fetch went the wrong way; qualified by res_valid
- res_redirect  in  ADDR_W  correct next fetch address

## Operation
- Index = addr[IDX_W-1:0]; tag = addr[ADDR_W-1:IDX_W]. Entry = {valid, tag, target, ctr}.
- Lookup combinational from pc; pred_* outputs depend only on pc and BTB state.
- Next-PC priority (when en=1): res_valid&res_mispredict -> res_redirect (overrides stall); else stall -> hold; else pred_taken -> pred_target; else pc_4.
- Training, when en=1 and res_valid=1, on entry at index(res_pc):
  - Hit, taken: ctr saturating +1, target <= res_target.
  - Hit, not taken: ctr saturating -1; entry stays valid.
  - Miss, taken: allocate (overwrite): valid=1, tag, target=res_target, ctr=2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change.
- bp_clear (when en=1) clears all valid bits; wins over same-cycle training. PC unaffected.
- Training and bp_clear are gated by en; stall does not block training.
- Reset: pc=0, all valid=0, all ctr=2^(CNT_W-1)-1 (weakly not taken). Outputs after reset: pc=0, pc_4=1, pred_hit=0, pred_taken=0, pred_target=0.
- Reset wins over en, redirect, training and bp_clear in the same cycle.

## Timing
- pc updates one cycle after the selecting condition; redirect visible on pc the cycle after res_valid.
- BTB write visible to lookup the following cycle; no same-cycle bypass (lookup of an index being written sees old contents).
- Zero-cycle prediction: pred_* valid in the same cycle pc is presented.
- pc_4 and pred_target arithmetic wrap modulo 2^ADDR_W; pc=2^ADDR_W-1 advances to 0.

## Test plan
- Reset, en=1, no branches 3 cycles -> pc 0,1,2,3; pred_hit=0 throughout; en=0 one cycle -> pc holds at 3.
- res_valid, res_pc=5, res_taken=1, res_target=0x20, no mispredict; later pc=5 -> pred_hit=1, pred_taken=1, pred_target=0x20; next pc=0x20.
- Counter saturation on pc 5: three not-taken updates -> ctr 2,1,0,0; pred_taken=0 after first; four taken updates -> ctr 1,2,3,3; pred_taken=1 from ctr=2.
- Alias: entry for pc 5 valid; pc=21 (same index, tag 1) -> pred_hit=0, next pc 22; taken res at 21 target 0x30 replaces entry; pc=5 then misses.
- stall=1 with res_valid, res_mispredict=1, res_redirect=0x40 -> pc=0x40 next cycle; stall=1 alone -> pc holds.
- pc=0x3FF, no hit -> next pc 0x000; bp_clear with res_valid allocating pc 7 in same cycle -> all entries invalid, pc 7 misses afterwards.
